// File: rtl/sc.sv
// Sequence counter: steps q through a packed code table, one entry per clock.
// count marks the cycle in which the last table entry is on q.
module sc #(
  parameter int WIDTH   = 3,
  parameter int SEQ_LEN = 8,
  parameter logic [SEQ_LEN*WIDTH-1:0] SEQ = {
    3'b100, 3'b101, 3'b111, 3'b110,
    3'b010, 3'b011, 3'b001, 3'b000
  }
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic             count
);

  localparam int IW = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

  if (SEQ_LEN < 2 || SEQ_LEN > 2**WIDTH) begin : g_bad_len
    $error("sc: SEQ_LEN must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] w_tab [SEQ_LEN];

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_tab
    assign w_tab[g] = SEQ[g*WIDTH +: WIDTH];
  end

  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_q;
  logic             r_count;
  logic [IW-1:0]    w_nxt;

  // An out-of-range index takes the same path as the wrap, back to entry 0.
  always_comb begin
    w_nxt = r_idx + IW'(1);
    if (r_idx >= LAST)
      w_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx   <= '0;
      r_q     <= w_tab[0];
      r_count <= 1'b0;
    end else begin
      r_idx   <= w_nxt;
      r_q     <= w_tab[w_nxt];
      r_count <= (w_nxt == LAST);
    end
  end

  assign q     = r_q;
  assign count = r_count;

endmodule

// File: tb/tb_sc.sv
// Directed bench for sc: default Gray table plus a 2-bit, 3-entry override,
// checked against a scoreboard fed by a small index model.
module tb_sc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] q3;
  logic       c3;
  logic [1:0] q2;
  logic       c2;

  always #5 clk = ~clk;

  sc u_dut (
    .clk   (clk),
    .rst   (rst),
    .q     (q3),
    .count (c3)
  );

  sc #(
    .WIDTH   (2),
    .SEQ_LEN (3),
    .SEQ     ({2'b10, 2'b01, 2'b00})
  ) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .q     (q2),
    .count (c2)
  );

  typedef struct packed {
    logic [2:0] q3;
    logic       c3;
    logic [1:0] q2;
    logic       c2;
  } exp_t;

  exp_t       sb [$];
  logic [2:0] gray [8];
  logic [1:0] tab2 [3];
  int         m3;
  int         m2;
  int         total;
  int         bad;
  logic [2:0] prev_q;
  bit         prev_run;

  task automatic step(input logic r);
    exp_t e;
    exp_t x;
    rst = r;
    if (!r) begin
      m3 = 0;
      m2 = 0;
    end else begin
      m3 = (m3 + 1) % 8;
      m2 = (m2 + 1) % 3;
    end
    e.q3 = gray[m3];
    e.c3 = (m3 == 7);
    e.q2 = tab2[m2];
    e.c2 = (m2 == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    total++;
    assert (q3 === x.q3) else begin
      bad++;
      $error("FAIL q3 got=%b exp=%b t=%0t", q3, x.q3, $time);
    end
    total++;
    assert (c3 === x.c3) else begin
      bad++;
      $error("FAIL count3 got=%b exp=%b t=%0t", c3, x.c3, $time);
    end
    total++;
    assert (q2 === x.q2) else begin
      bad++;
      $error("FAIL q2 got=%b exp=%b t=%0t", q2, x.q2, $time);
    end
    total++;
    assert (c2 === x.c2) else begin
      bad++;
      $error("FAIL count2 got=%b exp=%b t=%0t", c2, x.c2, $time);
    end
    if (r && prev_run) begin
      total++;
      assert ($countones(q3 ^ prev_q) == 1) else begin
        bad++;
        $error("FAIL onebit prev=%b got=%b", prev_q, q3);
      end
    end
    prev_q   = q3;
    prev_run = 1'b1;
  endtask

  initial begin
    gray[0] = 3'b000; gray[1] = 3'b001;
    gray[2] = 3'b011; gray[3] = 3'b010;
    gray[4] = 3'b110; gray[5] = 3'b111;
    gray[6] = 3'b101; gray[7] = 3'b100;
    tab2[0] = 2'b00;  tab2[1] = 2'b01;
    tab2[2] = 2'b10;
    total    = 0;
    bad      = 0;
    m3       = 0;
    m2       = 0;
    prev_q   = '0;
    prev_run = 1'b0;
    rst      = 1'b0;

    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 8; i++) step(1'b1);
    for (int i = 0; i < 25; i++) step(1'b1);

    for (int i = 0; i < 16 && m3 != 4; i++) step(1'b1);
    total++;
    assert (q3 === 3'b110) else begin
      bad++;
      $error("FAIL reach110 got=%b exp=%b", q3, 3'b110);
    end
    step(1'b0);
    step(1'b1);
    step(1'b1);

    for (int i = 0; i < 16 && m3 != 7; i++) step(1'b1);
    total++;
    assert (c3 === 1'b1) else begin
      bad++;
      $error("FAIL reachterm got=%b exp=%b", c3, 1'b1);
    end
    step(1'b0);
    step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
